// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte, valid/error pulses and activity flag out.
interface uart_rx_if;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_Frame_Err;
  modport master (output i_RX_Serial, input o_RX_DV, o_RX_Byte, o_RX_Active, o_Frame_Err);
  modport slave  (input i_RX_Serial, output o_RX_DV, o_RX_Byte, o_RX_Active, o_Frame_Err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, framing-error pulse and line-break hold.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input logic     i_Clock,
  input logic     i_Reset,
  uart_rx_if.slave rx
);
  localparam logic [9:0] H    = 10'((CLKS_PER_BIT - 1) / 2);
  localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT, CLEANUP, RX_BREAK} state_t;
  state_t      state;
  logic        rx_m, rx_s, err_p;
  logic [9:0]  count;
  logic [2:0]  idx;
  logic [7:0]  data;
  // The stop-bit verdict is published one clock later (from CLEANUP or via err_p) so both pulses leave from flops.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_m           <= 1'b1;
      rx_s           <= 1'b1;
      state          <= IDLE;
      count          <= '0;
      idx            <= '0;
      data           <= '0;
      err_p          <= 1'b0;
      rx.o_RX_DV     <= 1'b0;
      rx.o_Frame_Err <= 1'b0;
      rx.o_RX_Active <= 1'b0;
      rx.o_RX_Byte   <= '0;
    end else begin
      rx_m           <= rx.i_RX_Serial;
      rx_s           <= rx_m;
      rx.o_RX_DV     <= 1'b0;
      rx.o_Frame_Err <= err_p;
      err_p          <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          idx   <= '0;
          if (!rx_s) begin
            state          <= RX_START_BIT;
            rx.o_RX_Active <= 1'b1;
          end
        end
        RX_START_BIT:
          if (count == H) begin
            count          <= '0;
            state          <= rx_s ? IDLE : RX_DATA_BITS;
            rx.o_RX_Active <= !rx_s;
          end else count <= count + 10'd1;
        RX_DATA_BITS:
          if (count == LAST) begin
            count     <= '0;
            data[idx] <= rx_s;
            idx       <= idx + 3'd1;
            if (idx == 3'd7) state <= RX_STOP_BIT;
          end else count <= count + 10'd1;
        RX_STOP_BIT:
          if (count == LAST) begin
            count <= '0;
            state <= rx_s ? CLEANUP : RX_BREAK;
            err_p <= !rx_s;
          end else count <= count + 10'd1;
        CLEANUP: begin
          rx.o_RX_DV     <= 1'b1;
          rx.o_RX_Byte   <= data;
          rx.o_RX_Active <= 1'b0;
          state          <= IDLE;
        end
        RX_BREAK:
          if (rx_s) begin
            state          <= IDLE;
            rx.o_RX_Active <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level model with a pulse scoreboard.
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  typedef struct {bit err; logic [7:0] b; int at;} exp_t;
  exp_t       q[$];
  exp_t       em;
  logic [7:0] last_good = 8'h00;
  logic [7:0] held = 8'h00;
  bit         saw_active = 1'b0;

  uart_rx_if bus();
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (.i_Clock(clk), .i_Reset(rst), .rx(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // A frame starting low after edge k is first registered at k+1 (=E); its pulse must appear at E+4+H+9*CPB.
  task automatic send(input logic [7:0] b, input bit stop);
    bus.i_RX_Serial = 1'b0;
    if (stop) last_good = b;
    q.push_back('{err: !stop, b: last_good, at: cyc + 1 + 4 + (CPB - 1) / 2 + 9 * CPB});
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 bus.i_RX_Serial = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 bus.i_RX_Serial = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) held = 8'h00;
    else begin
      if (bus.o_RX_Active) saw_active = 1'b1;
      if (bus.o_RX_DV || bus.o_Frame_Err) begin
        chk(!(bus.o_RX_DV && bus.o_Frame_Err), "dv_ferr_exclusive", int'({bus.o_RX_DV, bus.o_Frame_Err}), 0);
        if (q.size() == 0) chk(1'b0, "unexpected_pulse", int'({bus.o_RX_DV, bus.o_Frame_Err}), 0);
        else begin
          em = q.pop_front();
          chk(bus.o_Frame_Err == em.err, "pulse_kind_ferr", int'(bus.o_Frame_Err), int'(em.err));
          chk(cyc == em.at, "pulse_cycle", cyc, em.at);
          chk(bus.o_RX_Byte == em.b, "rx_byte", int'(bus.o_RX_Byte), int'(em.b));
          held = em.b;
        end
      end else chk(bus.o_RX_Byte == held, "byte_hold", int'(bus.o_RX_Byte), int'(held));
    end
  end

  initial begin
    logic [7:0] rb;
    logic [7:0] p55;
    bit         rs;
    bus.i_RX_Serial = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk(bus.o_RX_DV == 1'b0, "reset_dv", int'(bus.o_RX_DV), 0);
    chk(bus.o_Frame_Err == 1'b0, "reset_ferr", int'(bus.o_Frame_Err), 0);
    chk(bus.o_RX_Active == 1'b0, "reset_active", int'(bus.o_RX_Active), 0);
    chk(bus.o_RX_Byte == 8'h00, "reset_byte", int'(bus.o_RX_Byte), 0);
    idle(5);
    send(8'hA5, 1'b1);
    idle(5);
    saw_active = 1'b0;
    bus.i_RX_Serial = 1'b0;
    idle(4);
    bus.i_RX_Serial = 1'b1;
    idle(CPB);
    chk(saw_active, "glitch_active_seen", int'(saw_active), 1);
    chk(bus.o_RX_Active == 1'b0, "glitch_back_idle", int'(bus.o_RX_Active), 0);
    send(8'h3C, 1'b0);
    idle(40);
    chk(bus.o_RX_Active == 1'b1, "break_held", int'(bus.o_RX_Active), 1);
    bus.i_RX_Serial = 1'b1;
    idle(4);
    chk(bus.o_RX_Active == 1'b0, "break_exit", int'(bus.o_RX_Active), 0);
    idle(3);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(5);
    p55 = 8'h55;
    bus.i_RX_Serial = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(CPB);
      bus.i_RX_Serial = p55[i];
    end
    idle(CPB / 2);
    rst = 1'b1;
    bus.i_RX_Serial = 1'b1;
    idle(3);
    rst = 1'b0;
    last_good = 8'h00;
    chk(bus.o_RX_Byte == 8'h00, "abort_byte_cleared", int'(bus.o_RX_Byte), 0);
    chk(bus.o_RX_Active == 1'b0, "abort_active", int'(bus.o_RX_Active), 0);
    idle(CPB * 12);
    chk(bus.o_RX_Active == 1'b0, "no_start_after_reset", int'(bus.o_RX_Active), 0);
    send(8'h81, 1'b1);
    idle(3);
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send(rb, rs);
      if (!rs) begin
        idle($urandom_range(0, 30));
        bus.i_RX_Serial = 1'b1;
        idle(4);
      end
      idle($urandom_range(0, 10));
    end
    for (int i = 0; i < 400 && q.size() > 0; i++) @(posedge clk);
    #1 chk(q.size() == 0, "pending_pulses", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per bit (i_Clock frequency / baud rate); legal range 4..1023.
REQ-002 SHALL have port i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_RX_Serial  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port o_RX_DV  output  1  one-clock pulse: a valid byte is on o_RX_Byte.
REQ-006 SHALL have port o_RX_Byte  output  8  last correctly received byte.
REQ-007 SHALL have port o_RX_Active  output  1  high from start-bit detection until return to IDLE.
REQ-008 SHALL have port o_Frame_Err  output  1  one-clock pulse: stop bit sampled low.

Function
REQ-009 SHALL pass i_RX_Serial through a 2-flop synchronizer; all decisions use the second flop (rx_s).
REQ-010 SHALL implement states IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT, CLEANUP, RX_BREAK.
REQ-011 SHALL use a 10-bit clock counter, a 3-bit bit index, and H = (CLKS_PER_BIT-1)/2 (integer division).
REQ-012 IDLE: counter=0, index=0; rx_s=0 -> RX_START_BIT, o_RX_Active=1; else stay.
REQ-013 RX_START_BIT: increment counter; at counter==H, rx_s=0 -> counter=0, RX_DATA_BITS; rx_s=1 -> glitch, IDLE, o_RX_Active=0, no output pulse.
REQ-014 RX_DATA_BITS: increment counter; at counter==CLKS_PER_BIT-1, store rx_s into shift data[index] (LSB first), counter=0; index<7 -> index+1; index==7 -> index=0, RX_STOP_BIT.
REQ-015 RX_STOP_BIT: at counter==CLKS_PER_BIT-1, sample rx_s: 1 -> o_RX_Byte<=data, o_RX_DV=1 for one clock, CLEANUP; 0 -> o_Frame_Err=1 for one clock, o_RX_Byte unchanged, RX_BREAK.
REQ-016 CLEANUP: one clock; o_RX_Active=0; -> IDLE.
REQ-017 RX_BREAK: stay while rx_s=0; rx_s=1 -> IDLE, o_RX_Active=0 (no re-triggering during line break).
REQ-018 Latency: if edge E is the first to register i_RX_Serial low, o_RX_DV is high in the cycle after edge E+4+H+9*CLKS_PER_BIT (CLKS_PER_BIT=16 -> E+155).
REQ-019 Data bits sampled at mid-bit; stop sampled at mid-stop, so IDLE is re-entered before the stop bit ends and a back-to-back frame with one stop bit is received without loss.
REQ-020 o_RX_DV and o_Frame_Err SHALL never be high simultaneously; each is high at most one clock per frame.
REQ-021 o_RX_Byte SHALL hold its value between valid frames.
REQ-022 Undefined state encodings SHALL go to IDLE next clock.

Reset
REQ-023 i_Reset=1 at a rising edge SHALL force: state IDLE, counters 0, shift data 0, synchronizer flops 1, o_RX_DV 0, o_Frame_Err 0, o_RX_Active 0, o_RX_Byte 0x00.
REQ-024 Reset SHALL take priority over all transitions, including mid-frame; a partial frame is discarded with no pulse.
REQ-025 After reset release, reception SHALL begin only on a subsequent low rx_s in IDLE.

Verification (CLKS_PER_BIT=16)
REQ-026 Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> single o_RX_DV pulse at E+155, o_RX_Byte=0xA5, o_Frame_Err never high.
REQ-027 Drive line low for 4 clocks, then high -> o_RX_Active pulses briefly, returns to IDLE, no o_RX_DV, no o_Frame_Err.
REQ-028 Send 0x3C with stop bit 0, hold line low 40 clocks, then high -> one o_Frame_Err pulse, o_RX_Byte keeps prior value, no o_RX_DV, state RX_BREAK until high, then IDLE.
REQ-029 Back-to-back 0x00 then 0xFF, one stop bit each, no idle gap -> two o_RX_DV pulses 160 clocks apart, bytes 0x00 then 0xFF.
REQ-030 Assert i_Reset during bit 4 of 0x55, release, send 0x81 -> no pulse for the aborted frame, o_RX_Byte=0x00 after reset, then 0x81 with one o_RX_DV.
